// File: rtl/ps2_ascii_receiver.sv
// PS/2 device-to-host receiver with scan-code set 2 letter decoder.
// Produces a held uppercase ASCII byte plus single-cycle event strobes
// (new key, key released, parity error, framing error) in the clk domain.
//
// Frame FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line idle, waiting for a falling edge with data low (start)
//   ST_DATA   | shifting 8 data bits, LSB first
//   ST_PARITY | next falling edge carries the odd-parity bit
//   ST_STOP   | next falling edge carries the stop bit; frame then closes
//
// Error strobes are routed through the decoder register so that every
// pulse output leaves from the same pipeline stage; the decoder only ever
// raises one of them per cycle.
module ps2_ascii_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter bit          CLEAR_ON_BREAK = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] ascii_code_o,
    output logic       ascii_valid_o,
    output logic       key_release_o,
    output logic       parity_err_o,
    output logic       framing_err_o
);

    localparam int unsigned          TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]     TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_ONE    = TMO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // synchroniser / edge detect
    logic ps2_clk_meta_q;
    logic ps2_clk_sync_q;
    logic ps2_clk_prev_q;
    logic ps2_data_meta_q;
    logic ps2_data_sync_q;
    logic fall;

    // frame FSM
    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       sr_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_q;
    logic             byte_done_q;
    logic             par_err_q;
    logic             frm_err_q;

    // decoder
    logic       map_hit;
    logic [7:0] map_ascii;
    logic [7:0] ascii_code_q, ascii_code_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       ascii_valid_q, ascii_valid_d;
    logic       key_release_q, key_release_d;
    logic       parity_err_q, parity_err_d;
    logic       framing_err_q, framing_err_d;

    // Two-flop synchronisers; lines idle high so reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk_i;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data_i;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign fall = ps2_clk_prev_q & ~ps2_clk_sync_q;

    // Frame FSM: collects one 11-bit frame and reports done / parity / framing.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            sr_q        <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_done_q <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            if (state_q == ST_IDLE) begin
                tmo_q <= '0;
                if (fall && !ps2_data_sync_q) begin
                    state_q   <= ST_DATA;
                    bit_cnt_q <= 3'd0;
                    tmo_q     <= TMO_RELOAD;
                end
            end else if (fall) begin
                tmo_q <= TMO_RELOAD;
                case (state_q)
                    ST_DATA: begin
                        sr_q      <= {ps2_data_sync_q, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= ps2_data_sync_q;
                        state_q <= ST_STOP;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        if (!ps2_data_sync_q) begin
                            frm_err_q <= 1'b1;
                        end else if (^{sr_q, par_q}) begin
                            byte_done_q <= 1'b1;
                        end else begin
                            par_err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (tmo_q == '0) begin
                // ps2_clk stalled mid-frame: abandon it
                state_q   <= ST_IDLE;
                frm_err_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q - TMO_ONE;
            end
        end
    end

    // Set-2 make code to uppercase letter lookup.
    always_comb begin
        map_hit   = 1'b1;
        map_ascii = 8'h00;
        case (sr_q)
            8'h1C: map_ascii = 8'h41; // A
            8'h32: map_ascii = 8'h42; // B
            8'h21: map_ascii = 8'h43; // C
            8'h23: map_ascii = 8'h44; // D
            8'h24: map_ascii = 8'h45; // E
            8'h2B: map_ascii = 8'h46; // F
            8'h34: map_ascii = 8'h47; // G
            8'h33: map_ascii = 8'h48; // H
            8'h43: map_ascii = 8'h49; // I
            8'h3B: map_ascii = 8'h4A; // J
            8'h42: map_ascii = 8'h4B; // K
            8'h4B: map_ascii = 8'h4C; // L
            8'h3A: map_ascii = 8'h4D; // M
            8'h31: map_ascii = 8'h4E; // N
            8'h44: map_ascii = 8'h4F; // O
            8'h4D: map_ascii = 8'h50; // P
            8'h15: map_ascii = 8'h51; // Q
            8'h2D: map_ascii = 8'h52; // R
            8'h1B: map_ascii = 8'h53; // S
            8'h2C: map_ascii = 8'h54; // T
            8'h3C: map_ascii = 8'h55; // U
            8'h2A: map_ascii = 8'h56; // V
            8'h1D: map_ascii = 8'h57; // W
            8'h22: map_ascii = 8'h58; // X
            8'h35: map_ascii = 8'h59; // Y
            8'h1A: map_ascii = 8'h5A; // Z
            default: map_hit = 1'b0;
        endcase
    end

    // Decoder next state: prefix flags, held code and the single active strobe.
    always_comb begin
        ascii_code_d  = ascii_code_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        ascii_valid_d = 1'b0;
        key_release_d = 1'b0;
        parity_err_d  = 1'b0;
        framing_err_d = 1'b0;
        if (par_err_q) begin
            parity_err_d = 1'b1;
            ext_d        = 1'b0;
            brk_d        = 1'b0;
        end else if (frm_err_q) begin
            framing_err_d = 1'b1;
            ext_d         = 1'b0;
            brk_d         = 1'b0;
        end else if (byte_done_q) begin
            if (sr_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (sr_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (ext_q) begin
                // extended keys are not letters; drop the whole sequence
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                brk_d = 1'b0;
                if (map_hit) begin
                    key_release_d = 1'b1;
                    if (CLEAR_ON_BREAK && (map_ascii == ascii_code_q)) begin
                        ascii_code_d = 8'h00;
                    end
                end
            end else if (map_hit) begin
                ascii_code_d  = map_ascii;
                ascii_valid_d = 1'b1;
            end
        end
    end

    // Decoder register stage.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ascii_code_q  <= 8'h00;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            ascii_valid_q <= 1'b0;
            key_release_q <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            ascii_code_q  <= ascii_code_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            ascii_valid_q <= ascii_valid_d;
            key_release_q <= key_release_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign ascii_code_o  = ascii_code_q;
    assign ascii_valid_o = ascii_valid_q;
    assign key_release_o = key_release_q;
    assign parity_err_o  = parity_err_q;
    assign framing_err_o = framing_err_q;

endmodule

// File: tb/tb_ps2_ascii_receiver.sv
// Bench for ps2_ascii_receiver: drives PS/2 frames, records every DUT strobe
// into a ring buffer and compares it against an expected-event queue.
module tb_ps2_ascii_receiver;

    localparam int TMO      = 2000;
    localparam int PS2_HALF = 40;   // clk cycles per half ps2_clk period

    localparam int EV_VALID   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_PERR    = 2;
    localparam int EV_FERR    = 3;
    localparam int EV_MULTI   = 4;

    typedef struct {
        int         kind;
        logic [7:0] code;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii_code;
    logic       ascii_valid;
    logic       key_release;
    logic       parity_err;
    logic       framing_err;

    int   cyc = 0;
    int   stop_cyc = 0;
    int   checks = 0;
    int   passed = 0;
    ev_t  exp_q[$];
    ev_t  obs_mem [0:255];
    int   obs_wr = 0;
    int   obs_rd = 0;

    ps2_ascii_receiver #(
        .TIMEOUT_CYCLES(TMO),
        .CLEAR_ON_BREAK(1'b0)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .ascii_code_o (ascii_code),
        .ascii_valid_o(ascii_valid),
        .key_release_o(key_release),
        .parity_err_o (parity_err),
        .framing_err_o(framing_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe seen by the DUT, tagged with the held code.
    always @(negedge clk) begin
        int  npulse;
        ev_t o;
        if (reset_n) begin
            npulse = int'(ascii_valid) + int'(key_release) + int'(parity_err) + int'(framing_err);
            if (npulse != 0) begin
                if (npulse > 1)        o.kind = EV_MULTI;
                else if (ascii_valid)  o.kind = EV_VALID;
                else if (key_release)  o.kind = EV_RELEASE;
                else if (parity_err)   o.kind = EV_PERR;
                else                   o.kind = EV_FERR;
                o.code = ascii_code;
                o.cyc  = cyc;
                obs_mem[obs_wr % 256] = o;
                obs_wr = obs_wr + 1;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int kind, input logic [7:0] code);
        ev_t e;
        e.kind = kind;
        e.code = code;
        e.cyc  = 0;
        exp_q.push_back(e);
    endtask

    // Send nfalls bits of a frame; data changes mid-high, sampled on fall.
    task automatic ps2_send(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input int nfalls);
        logic [10:0] f;
        f = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            repeat (PS2_HALF / 2) @(negedge clk);
            ps2_data = f[i];
            repeat (PS2_HALF / 2) @(negedge clk);
            ps2_clk  = 1'b0;
            stop_cyc = cyc;
            repeat (PS2_HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (PS2_HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] data);
        ps2_send(data, 1'b0, 1'b0, 11);
    endtask

    task automatic wait_events(input int n, input int budget);
        int k = 0;
        while ((obs_wr - obs_rd) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (ascii_code !== 8'h00) $display("FAIL reset_code: got %02h want 00", ascii_code); else passed++;
        checks++; if (ascii_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ascii_valid); else passed++;
        checks++; if (key_release !== 1'b0) $display("FAIL reset_release: got %b want 0", key_release); else passed++;
        checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", parity_err); else passed++;
        checks++; if (framing_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", framing_err); else passed++;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (ascii_code !== 8'h00) $display("FAIL post_reset_code: got %02h want 00", ascii_code); else passed++;
    endtask

    task automatic test_make();
        ev_t e, o;
        int  lat;
        push_exp(EV_VALID, 8'h45);
        send(8'h24);
        wait_events(1, 200);
        checks++;
        if (obs_wr == obs_rd) begin
            $display("FAIL make_latency: no strobe seen, want one within 5 clk");
        end else begin
            lat = obs_mem[obs_rd % 256].cyc - stop_cyc;
            if (lat > 5 || lat < 1) $display("FAIL make_latency: got %0d clk want <=5", lat);
            else passed++;
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd == obs_wr) $display("FAIL make_event: got none want kind=%0d code=%02h", e.kind, e.code);
            else begin
                o = obs_mem[obs_rd % 256]; obs_rd++;
                if (o.kind !== e.kind || o.code !== e.code)
                    $display("FAIL make_event: got kind=%0d code=%02h want kind=%0d code=%02h", o.kind, o.code, e.kind, e.code);
                else passed++;
            end
        end
        checks++; if (obs_rd != obs_wr) begin $display("FAIL make_extra: got %0d extra strobes want 0", obs_wr - obs_rd); obs_rd = obs_wr; end else passed++;
        checks++; if (ascii_code !== 8'h45) $display("FAIL make_code: got %02h want 45", ascii_code); else passed++;
    endtask

    task automatic test_break();
        ev_t e, o;
        push_exp(EV_VALID, 8'h45);
        push_exp(EV_RELEASE, 8'h45);
        send(8'h24);
        send(8'hF0);
        send(8'h24);
        wait_events(2, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd == obs_wr) $display("FAIL break_event: got none want kind=%0d code=%02h", e.kind, e.code);
            else begin
                o = obs_mem[obs_rd % 256]; obs_rd++;
                if (o.kind !== e.kind || o.code !== e.code)
                    $display("FAIL break_event: got kind=%0d code=%02h want kind=%0d code=%02h", o.kind, o.code, e.kind, e.code);
                else passed++;
            end
        end
        checks++; if (obs_rd != obs_wr) begin $display("FAIL break_extra: got %0d extra strobes want 0", obs_wr - obs_rd); obs_rd = obs_wr; end else passed++;
        checks++; if (ascii_code !== 8'h45) $display("FAIL break_code: got %02h want 45", ascii_code); else passed++;
    endtask

    task automatic test_frame_errors();
        ev_t e, o;
        push_exp(EV_PERR, 8'h45);
        ps2_send(8'h32, 1'b1, 1'b0, 11);
        push_exp(EV_FERR, 8'h45);
        ps2_send(8'h1C, 1'b0, 1'b1, 11);
        // a pending break prefix is discarded by an error
        send(8'hF0);
        push_exp(EV_PERR, 8'h45);
        ps2_send(8'h1C, 1'b1, 1'b0, 11);
        push_exp(EV_VALID, 8'h41);
        send(8'h1C);
        wait_events(4, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd == obs_wr) $display("FAIL err_event: got none want kind=%0d code=%02h", e.kind, e.code);
            else begin
                o = obs_mem[obs_rd % 256]; obs_rd++;
                if (o.kind !== e.kind || o.code !== e.code)
                    $display("FAIL err_event: got kind=%0d code=%02h want kind=%0d code=%02h", o.kind, o.code, e.kind, e.code);
                else passed++;
            end
        end
        checks++; if (obs_rd != obs_wr) begin $display("FAIL err_extra: got %0d extra strobes want 0", obs_wr - obs_rd); obs_rd = obs_wr; end else passed++;
    endtask

    task automatic test_extended();
        ev_t e, o;
        send(8'hE0);
        send(8'h75);
        push_exp(EV_RELEASE, 8'h41);
        send(8'hF0);
        send(8'h32);
        // extended break of a letter code is swallowed entirely
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        wait_events(1, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd == obs_wr) $display("FAIL ext_event: got none want kind=%0d code=%02h", e.kind, e.code);
            else begin
                o = obs_mem[obs_rd % 256]; obs_rd++;
                if (o.kind !== e.kind || o.code !== e.code)
                    $display("FAIL ext_event: got kind=%0d code=%02h want kind=%0d code=%02h", o.kind, o.code, e.kind, e.code);
                else passed++;
            end
        end
        checks++; if (obs_rd != obs_wr) begin $display("FAIL ext_extra: got %0d extra strobes want 0", obs_wr - obs_rd); obs_rd = obs_wr; end else passed++;
        checks++; if (ascii_code !== 8'h41) $display("FAIL ext_code: got %02h want 41", ascii_code); else passed++;
    endtask

    task automatic test_timeout();
        ev_t e, o;
        int  gap;
        push_exp(EV_FERR, 8'h41);
        ps2_send(8'h2B, 1'b0, 1'b0, 5);
        gap = cyc;
        wait_events(1, TMO + 500);
        checks++;
        if (obs_wr == obs_rd) $display("FAIL timeout_delay: no strobe seen");
        else if (obs_mem[obs_rd % 256].cyc - stop_cyc < TMO)
            $display("FAIL timeout_delay: got %0d clk want >= %0d", obs_mem[obs_rd % 256].cyc - stop_cyc, TMO);
        else passed++;
        push_exp(EV_VALID, 8'h46);
        send(8'h2B);
        wait_events(2, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd == obs_wr) $display("FAIL timeout_event: got none want kind=%0d code=%02h", e.kind, e.code);
            else begin
                o = obs_mem[obs_rd % 256]; obs_rd++;
                if (o.kind !== e.kind || o.code !== e.code)
                    $display("FAIL timeout_event: got kind=%0d code=%02h want kind=%0d code=%02h", o.kind, o.code, e.kind, e.code);
                else passed++;
            end
        end
        checks++; if (obs_rd != obs_wr) begin $display("FAIL timeout_extra: got %0d extra strobes want 0 (start %0d)", obs_wr - obs_rd, gap); obs_rd = obs_wr; end else passed++;
    endtask

    task automatic test_back_to_back();
        ev_t          e, o;
        logic [7:0]   codes [8];
        logic [7:0]   letters [8];
        codes   = '{8'h32, 8'h23, 8'h2D, 8'h1A, 8'h15, 8'h1C, 8'h1C, 8'h16};
        letters = '{8'h42, 8'h44, 8'h52, 8'h5A, 8'h51, 8'h41, 8'h41, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (letters[i] != 8'h00) push_exp(EV_VALID, letters[i]);
            send(codes[i]);
        end
        wait_events(7, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd == obs_wr) $display("FAIL b2b_event: got none want kind=%0d code=%02h", e.kind, e.code);
            else begin
                o = obs_mem[obs_rd % 256]; obs_rd++;
                if (o.kind !== e.kind || o.code !== e.code)
                    $display("FAIL b2b_event: got kind=%0d code=%02h want kind=%0d code=%02h", o.kind, o.code, e.kind, e.code);
                else passed++;
            end
        end
        checks++; if (obs_rd != obs_wr) begin $display("FAIL b2b_extra: got %0d extra strobes want 0", obs_wr - obs_rd); obs_rd = obs_wr; end else passed++;
        checks++; if (ascii_code !== 8'h41) $display("FAIL b2b_unmapped_code: got %02h want 41", ascii_code); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        ev_t e, o;
        ps2_send(8'h23, 1'b0, 1'b0, 6);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (ascii_code !== 8'h00) $display("FAIL midreset_code: got %02h want 00", ascii_code); else passed++;
        checks++;
        if ({ascii_valid, key_release, parity_err, framing_err} !== 4'b0000)
            $display("FAIL midreset_pulses: got %b want 0000", {ascii_valid, key_release, parity_err, framing_err});
        else passed++;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        push_exp(EV_VALID, 8'h52);
        send(8'h2D);
        wait_events(1, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd == obs_wr) $display("FAIL midreset_event: got none want kind=%0d code=%02h", e.kind, e.code);
            else begin
                o = obs_mem[obs_rd % 256]; obs_rd++;
                if (o.kind !== e.kind || o.code !== e.code)
                    $display("FAIL midreset_event: got kind=%0d code=%02h want kind=%0d code=%02h", o.kind, o.code, e.kind, e.code);
                else passed++;
            end
        end
        checks++; if (obs_rd != obs_wr) begin $display("FAIL midreset_extra: got %0d extra strobes want 0", obs_wr - obs_rd); obs_rd = obs_wr; end else passed++;
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_frame_errors();
        test_extended();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
